ex_muldiv_seq: RTL and testbench
================================

Name: ex_muldiv_seq

Overview:
Iterative RV32M multiply/divide sequencer attached to the EX stage. It accepts one M-extension operation from EX and runs a 32-iteration shift-add multiply or restoring divide. While the operation runs, it holds the EX stage with a stall. It returns the 32-bit result in the single cycle EX advances, which lets mem_alu capture it alongside the normal ALU path.

Parameters:
XLEN, 32, operand/result width; only 32 supported.
ITERS, XLEN, iterations in CALC; fixed to XLEN.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  EX holds a valid M-ext instruction; held high while stall=1.
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
op_a  input  32  forwarded rs1 (post forwarding mux).
op_b  input  32  forwarded rs2.
flush  input  1  EX kill (mispredict/flush); aborts any operation.
stall  output  1  freeze PC/IF/ID/EX registers; combinational.
done  output  1  result valid this cycle; EX advances this cycle.
result  output  32  registered result; held until next done.

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, result=0, done=0, internal regs=0. stall=0 while in reset.
- States: IDLE, CALC, DONE.
- IDLE, start=1, flush=0: latch funct3, operand magnitudes, sign flags; stall=1 this cycle.
  - Special divide case -> DONE next edge.
  - Otherwise -> CALC with counter=ITERS-1.
- CALC: one iteration per cycle; stall=1; counter decrements; at counter==0 -> DONE.
- Nominal timing: start at cycle 0, CALC cycles 1..32, DONE at cycle 33.
- DONE: done=1, stall=0, result valid. start is ignored this cycle (same instruction still present). Next edge -> IDLE.
- Back-to-back: a new start in the cycle after DONE is accepted normally.
- Signedness:
  - MULH: both operands signed. MULHSU: a signed, b unsigned. MUL/MULHU/DIVU/REMU: unsigned magnitudes.
  - DIV/REM: signed.
- Multiply: unsigned 32x32 -> 64-bit shift-add; 64-bit two's-complement negate if the sign flags differ. MUL returns [31:0]; MULH* return [63:32].
- Divide: restoring, unsigned magnitudes.
  - Quotient negated if sign(a)^sign(b) for DIV.
  - Remainder negated if sign(a) for REM.
  - Sign fix applied on the CALC->DONE transition.
- Special cases, resolved in IDLE, done at cycle 1:
  - Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> op_a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV -> 0x80000000, REM -> 0.
- flush=1 in any state: stall=0 and done=0 that cycle; -> IDLE next edge; result unchanged.
- flush with start in IDLE: the operation is not accepted.
- start deasserted during CALC (protocol violation): operation continues and is not checked.
- rst asserted mid-operation: immediate return to reset values.

Optional Feature:
MULDIV_EARLY_OUT_EN:
- Defined: a multiply leaves CALC after any iteration in which the remaining multiplier shift register becomes 0. Timing: DONE at cycle k+2, where k is the bit index of the highest set bit of |b|. b=0 -> DONE at cycle 2. Divide timing is unchanged.
- Undefined: all multiplies take the full 32 iterations (DONE at cycle 33).

Decomposition:
- Shared control-select header, alongside the existing mux selects:
  - funct3 codes.
  - state encodings (IDLE/CALC/DONE).
  - DIV0 quotient constant and ITERS.
- One sub-module, muldiv_iter: the 64-bit accumulator/remainder, multiplier/quotient shift registers, one-iteration step logic and sign fix.
- ex_muldiv_seq keeps the FSM, counter, special-case detect, stall/done.

Test Plan:
- MUL, op_a=7, op_b=0xFFFFFFFD -> done at cycle 33, result=0xFFFFFFEB; stall=1 cycles 0..32, 0 at 33.
- MULH, 0x80000000 x 0x80000000 -> result=0x40000000. MULHU, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV, -7/2 -> 0xFFFFFFFD; REM, -7/2 -> 0xFFFFFFFF; DIVU, 100/7 -> 14; REMU, 100/7 -> 2.
- DIV x/0 -> 0xFFFFFFFF with done at cycle 1. REM 0x12345678/0 -> 0x12345678. DIV 0x80000000/-1 -> 0x80000000 with done at cycle 1.
- Abort: flush at cycle 10 -> stall=0 that cycle, no done pulse, result unchanged; new start at cycle 12 completes at cycle 45.
- Reset: rst low at cycle 5 of a divide -> state IDLE, done=0, result=0 immediately. With MULDIV_EARLY_OUT_EN, MUL 5x3 -> result=15 with done at cycle 3.

Source files
------------

// File: rtl/ex_muldiv_seq_pkg.sv
// Shared control selects for the EX-stage RV32M multiply/divide sequencer:
// funct3 codes, FSM encodings, iteration count and the divide-by-zero quotient.
package ex_muldiv_seq_pkg;

    localparam int XLEN  = 32;
    localparam int ITERS = XLEN;
    localparam int CNT_W = $clog2(ITERS);
    localparam int W2    = 2 * XLEN;

    localparam logic [XLEN-1:0] DIV0_QUOT = '1;
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's-complement magnitude; INT_MIN maps to itself, which is correct as unsigned.
    function automatic logic [XLEN-1:0] to_mag(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_seq_muldiv_iter.sv
// Datapath for the sequencer: shift-add multiply / restoring divide, one step per cycle,
// plus the final sign fix. MULDIV_EARLY_OUT_EN enables the multiply early-out flag.
module muldiv_iter
    import ex_muldiv_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            load_div,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    input  logic            step,
    input  logic [2:0]      funct3,
    input  logic            negate,
    output logic [XLEN-1:0] result_fix,
    output logic            early_done
);

    // acc: product accumulator (mul) or partial remainder in [XLEN-1:0] (div)
    // mcand: shifting multiplicand (mul) or divisor in [XLEN-1:0] (div)
    // sreg: multiplier shifting right (mul) or dividend/quotient shifting left (div)
    logic [W2-1:0]   acc_q, mcand_q;
    logic [XLEN-1:0] sreg_q;
    logic [W2-1:0]   acc_nxt, mcand_nxt;
    logic [XLEN-1:0] sreg_nxt;
    logic [XLEN:0]   trial;
    logic [W2-1:0]   prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix;
    logic            is_div;

    assign is_div = funct3[2];

    always_comb begin
        acc_nxt   = acc_q;
        mcand_nxt = mcand_q;
        sreg_nxt  = sreg_q;
        trial     = {acc_q[XLEN-1:0], sreg_q[XLEN-1]} - {1'b0, mcand_q[XLEN-1:0]};
        if (is_div) begin
            // A clear borrow bit means the shifted remainder covered the divisor.
            if (!trial[XLEN]) begin
                acc_nxt  = {{XLEN{1'b0}}, trial[XLEN-1:0]};
                sreg_nxt = {sreg_q[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt  = {{XLEN{1'b0}}, acc_q[XLEN-2:0], sreg_q[XLEN-1]};
                sreg_nxt = {sreg_q[XLEN-2:0], 1'b0};
            end
        end else begin
            if (sreg_q[0]) begin
                acc_nxt = acc_q + mcand_q;
            end
            mcand_nxt = mcand_q << 1;
            sreg_nxt  = sreg_q >> 1;
        end
    end

    // Sign fix works on the final iteration's next-state so it lands with the CALC->DONE edge.
    always_comb begin
        prod_fix   = negate ? (~acc_nxt + {{(W2-1){1'b0}}, 1'b1}) : acc_nxt;
        quo_fix    = to_mag(sreg_nxt, negate);
        rem_fix    = to_mag(acc_nxt[XLEN-1:0], negate);
        result_fix = prod_fix[W2-1:XLEN];
        if (is_div) begin
            result_fix = funct3[1] ? rem_fix : quo_fix;
        end else if (funct3[1:0] == 2'b00) begin
            result_fix = prod_fix[XLEN-1:0];
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    assign early_done = !is_div && (sreg_nxt == '0);
`else
    assign early_done = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            mcand_q <= '0;
            sreg_q  <= '0;
        end else if (load) begin
            acc_q   <= '0;
            mcand_q <= {{XLEN{1'b0}}, (load_div ? b_mag : a_mag)};
            sreg_q  <= load_div ? a_mag : b_mag;
        end else if (step) begin
            acc_q   <= acc_nxt;
            mcand_q <= mcand_nxt;
            sreg_q  <= sreg_nxt;
        end
    end

endmodule

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer holding EX with a stall until the result is ready.
// Build option MULDIV_EARLY_OUT_EN lets multiplies finish once the multiplier runs out of set bits.
module ex_muldiv_seq
    import ex_muldiv_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output state_t          state_dbg
);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       f3_q;
    logic             neg_q;
    logic             done_q;

    logic            sign_a, sign_b, a_neg, b_neg, in_div;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div0, ovf, special, neg_in;
    logic [XLEN-1:0] special_res;
    logic            accept, step, last_iter, early_done;
    logic [XLEN-1:0] result_fix;

    // Operand decode for the instruction currently offered by EX.
    assign in_div = funct3[2];
    assign sign_a = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                    (funct3 == F3_DIV)  || (funct3 == F3_REM);
    assign sign_b = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    assign a_neg  = sign_a && op_a[XLEN-1];
    assign b_neg  = sign_b && op_b[XLEN-1];
    assign a_mag  = to_mag(op_a, a_neg);
    assign b_mag  = to_mag(op_b, b_neg);
    // Remainder follows the dividend's sign; quotient and product follow sign(a)^sign(b).
    assign neg_in = (in_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);

    assign div0    = in_div && (op_b == '0);
    assign ovf     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                     (op_a == INT_MIN) && (op_b == '1);
    assign special = div0 || ovf;

    always_comb begin
        special_res = DIV0_QUOT;
        if (div0) begin
            special_res = funct3[1] ? op_a : DIV0_QUOT;
        end else if (ovf) begin
            special_res = funct3[1] ? '0 : INT_MIN;
        end
    end

    assign accept    = (state_q == ST_IDLE) && start && !flush;
    assign step      = (state_q == ST_CALC) && !flush;
    assign last_iter = (cnt_q == '0) || early_done;

    muldiv_iter u_iter (
        .clk        (clk),
        .rst_n      (rst),
        .load       (accept && !special),
        .load_div   (in_div),
        .a_mag      (a_mag),
        .b_mag      (b_mag),
        .step       (step),
        .funct3     (f3_q),
        .negate     (neg_q),
        .result_fix (result_fix),
        .early_done (early_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
            result  <= '0;
        end else if (flush) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        f3_q  <= funct3;
                        neg_q <= neg_in;
                        if (special) begin
                            result  <= special_res;
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q   <= CNT_W'(ITERS - 1);
                            state_q <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (last_iter) begin
                        result  <= result_fix;
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // start is still the finishing instruction here, so it is not re-accepted.
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign stall     = rst && !flush &&
                       (((state_q == ST_IDLE) && start) || (state_q == ST_CALC));
    assign done      = done_q && !flush;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for ex_muldiv_seq: drivers push expected results and done cycles,
// a negedge monitor pops and compares them whenever done is presented.
module tb_ex_muldiv_seq;
  import ex_muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;
  state_t      state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  string       name_q[$];

  bit          in_done = 1'b0;
  logic [31:0] last_res = '0;
  logic [31:0] mon_exp;
  int          mon_cyc;
  string       mon_name;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_B_MSB1 = 3;
  localparam int LAT_B_ZERO = 2;
`else
  localparam int LAT_B_MSB1 = 33;
  localparam int LAT_B_ZERO = 33;
`endif

  ex_muldiv_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .stall     (stall),
    .done      (done),
    .result    (result),
    .state_dbg (state_dbg)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive one operation (called at a negedge) and hold start until done is seen.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int lat, input string name);
    int t0;
    bit stall_bad;
    bit got;
    t0 = in_done ? cyc + 1 : cyc;
    funct3 = f;
    op_a = a;
    op_b = b;
    start = 1'b1;
    exp_q.push_back(exp_res);
    exp_cyc_q.push_back(t0 + lat);
    name_q.push_back(name);
    stall_bad = 1'b0;
    got = 1'b0;
    if (!in_done) begin
      #1;
      if (stall !== 1'b1) stall_bad = 1'b1;
    end
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        if (stall !== 1'b0) stall_bad = 1'b1;
      end else if (stall !== 1'b1) begin
        stall_bad = 1'b1;
      end
    end
    in_done = got;
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no done want done within 100 cycles", name);
    end
    check({name, "_stall"}, {31'b0, stall_bad}, 32'd0);
    last_res = exp_res;
  endtask

  task automatic go_idle();
    start = 1'b0;
    @(negedge clk);
    in_done = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done with result %h want no done", result);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_cyc  = exp_cyc_q.pop_front();
        mon_name = name_q.pop_front();
        check({mon_name, "_result"}, result, mon_exp);
        check({mon_name, "_done_cyc"}, cyc, mon_cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; start = 1'b0; flush = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0;

    // reset state, including stall held low with start asserted
    @(negedge clk);
    check("rst_result", result, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    start = 1'b1;
    #1;
    check("rst_stall", {31'b0, stall}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // back-to-back directed vectors
    run_op(F3_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_7xm3");
    run_op(F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh_min");
    run_op(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max");
    run_op(F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, LAT_B_MSB1, "mulhsu_m1x2");
    run_op(F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "div_m7_2");
    run_op(F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "rem_m7_2");
    run_op(F3_DIVU,   32'd100,       32'd7,         32'd14,        33, "divu_100_7");
    run_op(F3_REMU,   32'd100,       32'd7,         32'd2,         33, "remu_100_7");
    run_op(F3_DIV,    32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 1,  "div_by0");
    run_op(F3_REM,    32'h1234_5678, 32'd0,         32'h1234_5678, 1,  "rem_by0");
    run_op(F3_REMU,   32'd5,         32'd0,         32'd5,         1,  "remu_by0");
    run_op(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf");
    run_op(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  "rem_ovf");
    run_op(F3_MUL,    32'd5,         32'd3,         32'd15,        LAT_B_MSB1, "mul_5x3");
    run_op(F3_MUL,    32'd9,         32'd0,         32'd0,         LAT_B_ZERO, "mul_9x0");
    run_op(F3_DIV,    32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, "div_100_m7");

    // flush at cycle 10 of a multiply, restart at cycle 12
    go_idle();
    funct3 = F3_MUL; op_a = 32'd1234; op_b = 32'd5678; start = 1'b1;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_stall", {31'b0, stall}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    check("flush_state", 32'(state_dbg), 32'(ST_IDLE));
    check("flush_result", result, last_res);
    @(negedge clk);
    run_op(F3_DIVU, 32'd1000, 32'd7, 32'd142, 33, "post_flush_divu");

    // asynchronous reset in cycle 5 of a divide
    go_idle();
    funct3 = F3_DIV; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_stall", {31'b0, stall}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    last_res = '0;
    repeat (2) @(negedge clk);
    run_op(F3_REM, 32'd1000, 32'd3, 32'd1, 33, "post_rst_rem");

    go_idle();
    repeat (3) @(negedge clk);
    check("drain", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
